// File: rtl/rib_uart_tx_slave.sv
// RIB responder with a buffered 8N1 UART transmitter.
// Bus writes fill a TX FIFO; a baud-timed FSM shifts bytes out LSB first.
module rib_uart_tx_slave #(
    parameter int FIFO_DEPTH  = 8,
    parameter int DIV_W       = 16,
    parameter int DIV_DEFAULT = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ready_o,
    output logic        tx_pin,
    output logic        irq_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(16);
    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_DEFAULT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic             r_en;
    logic             r_ie;
    logic [DIV_W-1:0] r_baud;
    logic             r_ready;
    logic [31:0]      r_rdata;

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    state_t           r_state;
    logic [7:0]       r_shift;
    logic [2:0]       r_bit;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;

    state_t           w_state_nxt;
    logic [7:0]       w_shift_nxt;
    logic [2:0]       w_bit_nxt;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic [DIV_W-1:0] w_div_nxt;
    logic             w_pop;
    logic             w_tx;
    logic             w_load;
    logic             w_tick;

    logic [1:0]       w_sel;
    logic             w_full;
    logic             w_empty;
    logic             w_busy;
    logic             w_accept;
    logic             w_push;
    logic [31:0]      w_rdata;
    logic             w_unused;

    assign w_sel   = addr_i[3:2];
    assign w_full  = (r_count == CW'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_busy  = (r_state != S_IDLE);

    // A TXDATA write into a full FIFO is held off until a slot frees.
    assign w_accept = req_i & ~r_ready
                    & ~(we_i & (w_sel == 2'd3) & w_full);
    assign w_push   = w_accept & we_i & (w_sel == 2'd3);

    assign w_unused = ^{addr_i[31:4], addr_i[1:0], data_i};

    always_comb begin
        w_rdata = '0;
        unique case (w_sel)
            2'd0: w_rdata[1:0] = {r_ie, r_en};
            2'd1: begin
                w_rdata[0]      = w_busy;
                w_rdata[1]      = w_full;
                w_rdata[2]      = w_empty;
                w_rdata[4 +: CW] = r_count;
            end
            2'd2: w_rdata[DIV_W-1:0] = r_baud;
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
            r_en    <= 1'b0;
            r_ie    <= 1'b0;
            r_baud  <= DIV_RST;
        end else begin
            r_ready <= w_accept;
            r_rdata <= (w_accept & ~we_i) ? w_rdata : '0;
            if (w_accept & we_i) begin
                if (w_sel == 2'd0) begin
                    r_en <= data_i[0];
                    r_ie <= data_i[1];
                end
                if (w_sel == 2'd2) begin
                    r_baud <= (data_i[DIV_W-1:0] < DIV_MIN)
                            ? DIV_MIN : data_i[DIV_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= data_i[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_push & ~w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (~w_push & w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    assign w_load = r_en & ~w_empty;
    assign w_tick = (r_cnt == r_div - DIV_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_bit   <= '0;
            r_cnt   <= '0;
            r_div   <= DIV_RST;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_bit   <= w_bit_nxt;
            r_cnt   <= w_cnt_nxt;
            r_div   <= w_div_nxt;
        end
    end

    // The divisor is captured with each byte so BAUD writes land on the next frame.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_bit_nxt   = r_bit;
        w_cnt_nxt   = r_cnt;
        w_div_nxt   = r_div;
        w_pop       = 1'b0;
        w_tx        = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                if (w_load) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = r_mem[r_rptr];
                    w_div_nxt   = r_baud;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_tx = 1'b0;
                if (w_tick) begin
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = S_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + DIV_W'(1);
                end
            end
            S_DATA: begin
                w_tx = r_shift[0];
                if (w_tick) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + DIV_W'(1);
                end
            end
            S_STOP: begin
                w_tx = 1'b1;
                if (w_tick) begin
                    w_cnt_nxt = '0;
                    if (w_load) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = r_mem[r_rptr];
                        w_div_nxt   = r_baud;
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + DIV_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign data_o  = r_rdata;
    assign ready_o = r_ready;
    assign tx_pin  = w_tx;
    assign irq_o   = r_en & r_ie & w_empty & ~w_busy;

endmodule

// File: tb/tb_rib_uart_tx_slave.sv
// Directed bench for rib_uart_tx_slave: registers, 8N1 waveform, FIFO stall,
// BAUD latching, mid-frame reset and interrupt behaviour.
module tb_rib_uart_tx_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        ready_o;
    logic        tx_pin;
    logic        irq_o;

    int n_chk  = 0;
    int n_pass = 0;
    bit cap_en = 1'b0;
    logic q_tx[$];

    localparam logic [31:0] A_CTRL = 32'h0;
    localparam logic [31:0] A_STAT = 32'h4;
    localparam logic [31:0] A_BAUD = 32'h8;
    localparam logic [31:0] A_TXD  = 32'hC;

    rib_uart_tx_slave dut (
        .clk    (clk),
        .rst    (rst),
        .req_i  (req_i),
        .we_i   (we_i),
        .addr_i (addr_i),
        .data_i (data_i),
        .data_o (data_o),
        .ready_o(ready_o),
        .tx_pin (tx_pin),
        .irq_o  (irq_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cap_en) q_tx.push_back(tx_pin);
    end

    task automatic bus(input logic we, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd,
                       output int lat);
        bit seen;
        req_i = 1'b1; we_i = we; addr_i = a; data_i = d;
        lat = 0; rd = '0; seen = 1'b0;
        while (lat < 50 && !seen) begin
            @(posedge clk); #1;
            lat++;
            if (ready_o) seen = 1'b1;
        end
        rd = data_o;
        if (!seen) begin
            n_chk++;
            $display("FAIL bus_timeout addr=%h: no ready_o within %0d cycles", a, lat);
        end
        req_i = 1'b0; we_i = 1'b0; addr_i = '0; data_i = '0;
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd;
        int lat;
        bus(1'b1, a, d, rd, lat);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        int lat;
        bus(1'b0, a, '0, v, lat);
    endtask

    function automatic int first_low();
        for (int i = 0; i < q_tx.size(); i++)
            if (q_tx[i] === 1'b0) return i;
        return -1;
    endfunction

    function automatic int frame_errs(int s, int div, logic [7:0] b);
        int errs;
        logic e;
        errs = 0;
        if (s < 0) return 999;
        for (int j = 0; j < 10; j++) begin
            e = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : b[j-1];
            for (int c = 0; c < div; c++) begin
                if (s + j*div + c >= q_tx.size()) errs++;
                else if (q_tx[s + j*div + c] !== e) errs++;
            end
        end
        return errs;
    endfunction

    function automatic int ones_errs(int from, int n);
        int errs;
        errs = 0;
        for (int i = from; i < from + n; i++)
            if (i < 0 || i >= q_tx.size() || q_tx[i] !== 1'b1) errs++;
        return errs;
    endfunction

    task automatic test_reset();
        logic [31:0] v;
        int lat;
        rst = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; data_i = '0;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (ready_o !== 1'b0) $display("FAIL rst_ready got %b want 0", ready_o); else n_pass++;
        n_chk++; if (data_o !== 32'h0) $display("FAIL rst_data got %h want 0", data_o); else n_pass++;
        n_chk++; if (tx_pin !== 1'b1) $display("FAIL rst_tx got %b want 1", tx_pin); else n_pass++;
        n_chk++; if (irq_o !== 1'b0) $display("FAIL rst_irq got %b want 0", irq_o); else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
        bus(1'b0, A_BAUD, '0, v, lat);
        n_chk++; if (v !== 32'd434) $display("FAIL baud_reset got %0d want 434", v); else n_pass++;
        n_chk++; if (lat !== 1) $display("FAIL ready_latency got %0d want 1", lat); else n_pass++;
        n_chk++; if (ready_o !== 1'b0) $display("FAIL ready_pulse got %b want 0", ready_o); else n_pass++;
        n_chk++; if (data_o !== 32'h0) $display("FAIL data_idle got %h want 0", data_o); else n_pass++;
        rd(A_STAT, v);
        n_chk++; if (v !== 32'h4) $display("FAIL status_reset got %h want 4", v); else n_pass++;
        rd(A_CTRL, v);
        n_chk++; if (v !== 32'h0) $display("FAIL ctrl_reset got %h want 0", v); else n_pass++;
        bus(1'b1, A_STAT, 32'hFFFF_FFFF, v, lat);
        n_chk++; if (lat !== 1) $display("FAIL ro_write_ack got %0d want 1", lat); else n_pass++;
        rd(A_STAT, v);
        n_chk++; if (v !== 32'h4) $display("FAIL ro_write_ignored got %h want 4", v); else n_pass++;
        rd(A_TXD, v);
        n_chk++; if (v !== 32'h0) $display("FAIL txdata_read got %h want 0", v); else n_pass++;
    endtask

    task automatic test_single_frame();
        logic [31:0] v;
        int s, e;
        wr(A_BAUD, 32'd16);
        wr(A_CTRL, 32'h1);
        q_tx.delete(); cap_en = 1'b1;
        wr(A_TXD, 32'hA5);
        rd(A_STAT, v);
        n_chk++; if (v !== 32'h5) $display("FAIL busy_midframe got %h want 5", v); else n_pass++;
        repeat (180) @(posedge clk);
        #1; cap_en = 1'b0;
        s = first_low();
        e = frame_errs(s, 16, 8'hA5);
        n_chk++; if (e !== 0) $display("FAIL frame_a5 got %0d bad samples want 0", e); else n_pass++;
        e = ones_errs(s + 160, 10);
        n_chk++; if (e !== 0) $display("FAIL a5_idle_after got %0d bad samples want 0", e); else n_pass++;
        rd(A_STAT, v);
        n_chk++; if (v !== 32'h4) $display("FAIL status_after_a5 got %h want 4", v); else n_pass++;
        n_chk++; if (irq_o !== 1'b0) $display("FAIL irq_ie0 got %b want 0", irq_o); else n_pass++;
    endtask

    task automatic test_fifo_stall();
        logic [7:0] b [10] = '{8'h01, 8'h80, 8'h55, 8'hAA, 8'hF0,
                               8'h0F, 8'h3C, 8'hC3, 8'h99, 8'h66};
        logic [31:0] v;
        int lat, hi, k, fall, s, e;
        logic prev;
        bit seen;
        wr(A_CTRL, 32'h0);
        for (int i = 0; i < 8; i++) wr(A_TXD, {24'h0, b[i]});
        rd(A_STAT, v);
        n_chk++; if (v !== 32'h82) $display("FAIL status_full got %h want 82", v); else n_pass++;
        n_chk++; if (tx_pin !== 1'b1) $display("FAIL tx_hold_en0 got %b want 1", tx_pin); else n_pass++;
        req_i = 1'b1; we_i = 1'b1; addr_i = A_TXD; data_i = {24'h0, b[8]};
        hi = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (ready_o) hi++;
        end
        req_i = 1'b0; we_i = 1'b0;
        @(posedge clk); #1;
        n_chk++; if (hi !== 0) $display("FAIL stall_full got %0d acks want 0", hi); else n_pass++;
        rd(A_STAT, v);
        n_chk++; if (v !== 32'h82) $display("FAIL stall_no_push got %h want 82", v); else n_pass++;
        q_tx.delete(); cap_en = 1'b1;
        wr(A_CTRL, 32'h1);
        n_chk++; if (tx_pin !== 1'b0) $display("FAIL first_pop got %b want 0", tx_pin); else n_pass++;
        bus(1'b1, A_TXD, {24'h0, b[8]}, v, lat);
        n_chk++; if (lat !== 1) $display("FAIL ack9_after_pop got %0d want 1", lat); else n_pass++;
        req_i = 1'b1; we_i = 1'b1; addr_i = A_TXD; data_i = {24'h0, b[9]};
        k = 0; fall = -100; prev = tx_pin; seen = 1'b0;
        while (k < 400 && !seen) begin
            @(posedge clk); #1;
            k++;
            if (prev === 1'b1 && tx_pin === 1'b0) fall = k;
            prev = tx_pin;
            if (ready_o) seen = 1'b1;
        end
        req_i = 1'b0; we_i = 1'b0;
        @(posedge clk); #1;
        n_chk++; if (k - fall !== 1) $display("FAIL stall_release got %0d cycles after pop want 1", k - fall); else n_pass++;
        repeat (1500) @(posedge clk);
        #1; cap_en = 1'b0;
        s = first_low();
        for (int i = 0; i < 10; i++) begin
            e = frame_errs(s + i*160, 16, b[i]);
            n_chk++; if (e !== 0) $display("FAIL b2b_frame%0d got %0d bad samples want 0", i, e); else n_pass++;
        end
        e = ones_errs(s + 1600, 20);
        n_chk++; if (e !== 0) $display("FAIL b2b_idle_after got %0d bad samples want 0", e); else n_pass++;
        rd(A_STAT, v);
        n_chk++; if (v !== 32'h4) $display("FAIL status_drained got %h want 4", v); else n_pass++;
    endtask

    task automatic test_baud_latch();
        logic [31:0] v;
        int s, e;
        q_tx.delete(); cap_en = 1'b1;
        wr(A_TXD, 32'h3C);
        wr(A_TXD, 32'hC3);
        wr(A_BAUD, 32'd32);
        repeat (520) @(posedge clk);
        #1; cap_en = 1'b0;
        s = first_low();
        e = frame_errs(s, 16, 8'h3C);
        n_chk++; if (e !== 0) $display("FAIL baud_cur_frame got %0d bad samples want 0", e); else n_pass++;
        e = frame_errs(s + 160, 32, 8'hC3);
        n_chk++; if (e !== 0) $display("FAIL baud_next_frame got %0d bad samples want 0", e); else n_pass++;
        e = ones_errs(s + 480, 20);
        n_chk++; if (e !== 0) $display("FAIL baud_idle_after got %0d bad samples want 0", e); else n_pass++;
        rd(A_BAUD, v);
        n_chk++; if (v !== 32'd32) $display("FAIL baud_32 got %0d want 32", v); else n_pass++;
        wr(A_BAUD, 32'd5);
        rd(A_BAUD, v);
        n_chk++; if (v !== 32'd16) $display("FAIL baud_clamp got %0d want 16", v); else n_pass++;
    endtask

    task automatic test_mid_reset();
        logic [31:0] v;
        int lows;
        wr(A_TXD, 32'h00);
        wr(A_TXD, 32'h00);
        repeat (70) @(posedge clk);
        #1;
        n_chk++; if (tx_pin !== 1'b0) $display("FAIL data_bit3 got %b want 0", tx_pin); else n_pass++;
        rst = 1'b1;
        @(posedge clk); #1;
        n_chk++; if (tx_pin !== 1'b1) $display("FAIL tx_after_rst got %b want 1", tx_pin); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        rd(A_STAT, v);
        n_chk++; if (v !== 32'h4) $display("FAIL rst_fifo_empty got %h want 4", v); else n_pass++;
        rd(A_CTRL, v);
        n_chk++; if (v !== 32'h0) $display("FAIL rst_ctrl got %h want 0", v); else n_pass++;
        rd(A_BAUD, v);
        n_chk++; if (v !== 32'd434) $display("FAIL rst_baud got %0d want 434", v); else n_pass++;
        lows = 0;
        repeat (200) begin
            @(posedge clk); #1;
            if (tx_pin !== 1'b1) lows++;
        end
        n_chk++; if (lows !== 0) $display("FAIL no_residual got %0d low cycles want 0", lows); else n_pass++;
        wr(A_BAUD, 32'd16);
    endtask

    task automatic test_irq();
        logic [31:0] v;
        int k;
        bit seen;
        wr(A_CTRL, 32'h3);
        n_chk++; if (irq_o !== 1'b1) $display("FAIL irq_empty got %b want 1", irq_o); else n_pass++;
        rd(A_CTRL, v);
        n_chk++; if (v !== 32'h3) $display("FAIL ctrl_rw got %h want 3", v); else n_pass++;
        wr(A_TXD, 32'h55);
        n_chk++; if (irq_o !== 1'b0) $display("FAIL irq_drop got %b want 0", irq_o); else n_pass++;
        n_chk++; if (tx_pin !== 1'b0) $display("FAIL irq_frame_start got %b want 0", tx_pin); else n_pass++;
        k = 0; seen = 1'b0;
        while (k < 300 && !seen) begin
            @(posedge clk); #1;
            k++;
            if (irq_o) seen = 1'b1;
        end
        n_chk++; if (k !== 160) $display("FAIL irq_rise got %0d cycles want 160", k); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_fifo_stall();
        test_baud_latch();
        test_mid_reset();
        test_irq();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
